alu_unit: RTL
=============

Name: alu_unit

Overview:
- Execution stage directly downstream of the arithmetic reservation station.
- Each cycle it takes one dispatched operation: op, Vj, Vk, imm, pc and ROB tag. NOP with tag 0 means idle.
- It computes the integer result, branch outcome or memory address, and registers the outcome onto the ALU common data bus (CDB) one cycle later.
- The CDB output feeds the ROB, the reservation stations and the load/store buffer.
- It also keeps two free-running statistics counters for performance debug.

Parameters:
- DATA_W, 32, operand/result width.
- ROB_W, 4, ROB tag width; tag 0 means "no entry".
- OP_W, 6, operation code width; codes come from the shared constant header.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ena  in  1  global enable; low = stall, all state held
- in_flush  in  1  mispredict flush from ROB
- in_op  in  OP_W  operation code (NOP when idle)
- in_Vj  in  DATA_W  operand j
- in_Vk  in  DATA_W  operand k
- in_imm  in  DATA_W  sign-extended immediate
- in_pc  in  DATA_W  instruction PC
- in_rob_tag  in  ROB_W  destination ROB entry
- out_cdb_rob_tag  out  ROB_W  broadcast tag; 0 = no broadcast
- out_cdb_data  out  DATA_W  result value, or effective address for memory ops
- out_cdb_isload  out  1  data is a load/store address; not a register value
- out_br_valid  out  1  broadcast carries a control-flow outcome
- out_br_taken  out  1  branch/jump taken
- out_br_target  out  DATA_W  resolved target PC
- out_issue_cnt  out  CNT_W  count of non-NOP operations executed
- out_taken_cnt  out  CNT_W  count of taken branches/jumps

Behaviour:
- Reset values: all outputs 0, including both counters.
- Priority each rising edge: rst > in_flush > !ena > normal.
- in_flush with rst low:
  - all out_cdb_*/out_br_* registers cleared to 0; counters held.
  - The input on that edge is discarded, even though ena is high.
- ena low: every register holds its value, so the CDB broadcast repeats. Downstream is idempotent on a repeated tag.
- Normal operation:
  - Latency exactly 1 cycle, throughput 1 operation per cycle, no internal buffering.
  - in_op == NOP or in_rob_tag == 0: outputs cleared to 0 on the next edge. An empty slot never re-broadcasts a stale tag.
- Result rules, all arithmetic mod 2^32:
  - ADD/SUB/AND/OR/XOR: Vj op Vk.
  - ADDI/ANDI/ORI/XORI: Vj op imm.
  - SLL/SRL/SRA: shift Vj by Vk[4:0]. Immediate shifts use imm[4:0]. SRA is arithmetic.
  - SLT/SLTI: signed compare; SLTU/SLTIU: unsigned compare. Result is 1 or 0.
  - LUI: imm. AUIPC: pc+imm.
  - JAL: data pc+4; br_valid=1, taken=1, target pc+imm.
  - JALR: data pc+4; br_valid=1, taken=1, target (Vj+imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU:
    - br_valid=1, target pc+imm, taken per compare of Vj,Vk (signed for BLT/BGE).
    - data = {31'b0, taken}.
  - Loads/stores: data = Vj+imm, isload=1, br_valid=0.
  - Unknown op code: handled as NOP (no broadcast).
- out_cdb_isload=0 for every non-memory op. out_br_target=0 when br_valid=0.
- Counters:
  - Increment on the same edge the result is registered, only under normal operation with a non-NOP op.
  - out_taken_cnt increments only when out_br_taken will be 1.
  - Both wrap at 2^CNT_W to 0.
- A flush asserted while a result is already on the CDB clears it on the next edge; the in-flight result visible this cycle is still visible for this cycle.

Test Plan:
1. Reset, then ADD Vj=5 Vk=7 tag=3 with ena=1 -> next cycle tag=3, data=12, isload=0, br_valid=0; issue_cnt=1.
2. BLT Vj=0xFFFFFFFF Vk=1 pc=0x100 imm=0x20 tag=2 -> taken=1, target=0x120, data=1. Then BLTU with the same operands -> taken=0, data=0; taken_cnt stays 1.
3. JALR Vj=0x1003 imm=4 pc=0x40 tag=5 -> data=0x44, target=0x1006, taken=1. Back-to-back NOP next cycle -> tag=0, all outputs 0.
4. LW Vj=0x2000 imm=-4 tag=7 -> data=0x1FFC, isload=1. Then drop ena for 3 cycles -> outputs and counters frozen at those values.
5. SRA Vj=0x80000000 Vk=0x24 -> shift 4, data=0xF8000000. Same op with in_flush=1 -> outputs 0, counters unchanged.
6. Preload counters to 0xFFFFFFFF via forced state, then issue a taken JAL -> both counters wrap to 0. Assert rst mid-stream -> all outputs 0 next edge.

Source files
------------

// File: rtl/alu_if.sv
// Dispatch-side and CDB-side signals of the ALU execution stage.
// The master (reservation station side) drives in_* and ena. The slave (alu_unit) drives out_*.
interface alu_if #(
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 32
);
  logic              ena;
  logic              in_flush;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_Vj;
  logic [DATA_W-1:0] in_Vk;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] in_pc;
  logic [ROB_W-1:0]  in_rob_tag;
  logic [ROB_W-1:0]  out_cdb_rob_tag;
  logic [DATA_W-1:0] out_cdb_data;
  logic              out_cdb_isload;
  logic              out_br_valid;
  logic              out_br_taken;
  logic [DATA_W-1:0] out_br_target;
  logic [CNT_W-1:0]  out_issue_cnt;
  logic [CNT_W-1:0]  out_taken_cnt;

  // There is no valid/ready handshake here. A slot is valid when in_op is not NOP and in_rob_tag is not 0.
  // The stage always accepts a valid slot when ena is high.
  // A nonzero out_cdb_rob_tag marks a broadcast, and it repeats for as long as ena is low.
  modport master (
    output ena, in_flush, in_op, in_Vj, in_Vk, in_imm, in_pc, in_rob_tag,
    input  out_cdb_rob_tag, out_cdb_data, out_cdb_isload, out_br_valid,
           out_br_taken, out_br_target, out_issue_cnt, out_taken_cnt
  );
  modport slave (
    input  ena, in_flush, in_op, in_Vj, in_Vk, in_imm, in_pc, in_rob_tag,
    output out_cdb_rob_tag, out_cdb_data, out_cdb_isload, out_br_valid,
           out_br_taken, out_br_target, out_issue_cnt, out_taken_cnt
  );
endinterface

// File: rtl/alu_unit.sv
// Single-cycle integer ALU / branch / address stage. It registers its result onto the ALU CDB
// and keeps issue and taken-branch statistics.
module alu_unit #(
   parameter int DATA_W = 32,
   parameter int ROB_W  = 4,
   parameter int OP_W   = 6,
   parameter int CNT_W  = 32
) (
   input logic clk,
   input logic rst,
   alu_if.slave bus
);
   localparam int SH_W = $clog2(DATA_W);

   localparam logic [OP_W-1:0] OP_NOP = 6'd0,  OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_AND = 6'd3;
   localparam logic [OP_W-1:0] OP_OR = 6'd4,   OP_XOR = 6'd5,  OP_ADDI = 6'd6, OP_ANDI = 6'd7;
   localparam logic [OP_W-1:0] OP_ORI = 6'd8,  OP_XORI = 6'd9, OP_SLL = 6'd10, OP_SRL = 6'd11;
   localparam logic [OP_W-1:0] OP_SRA = 6'd12, OP_SLLI = 6'd13, OP_SRLI = 6'd14, OP_SRAI = 6'd15;
   localparam logic [OP_W-1:0] OP_SLT = 6'd16, OP_SLTU = 6'd17, OP_SLTI = 6'd18, OP_SLTIU = 6'd19;
   localparam logic [OP_W-1:0] OP_LUI = 6'd20, OP_AUIPC = 6'd21, OP_JAL = 6'd22, OP_JALR = 6'd23;
   localparam logic [OP_W-1:0] OP_BEQ = 6'd24, OP_BNE = 6'd25, OP_BLT = 6'd26, OP_BGE = 6'd27;
   localparam logic [OP_W-1:0] OP_BLTU = 6'd28, OP_BGEU = 6'd29, OP_LB = 6'd30, OP_LH = 6'd31;
   localparam logic [OP_W-1:0] OP_LW = 6'd32, OP_LBU = 6'd33, OP_LHU = 6'd34, OP_SB = 6'd35;
   localparam logic [OP_W-1:0] OP_SH = 6'd36, OP_SW = 6'd37;

   logic [DATA_W-1:0] vj, vk, imm, pc;
   logic              known;
   logic              slot_valid;
   logic [DATA_W-1:0] res_data, res_target;
   logic              res_isload, res_br_valid, res_taken;
   logic              lt_s, lt_u, eq;

   logic [ROB_W-1:0]  tag_q;
   logic [DATA_W-1:0] data_q, target_q;
   logic              isload_q, br_valid_q, taken_q;
   logic [CNT_W-1:0]  issue_cnt_q, taken_cnt_q;

   assign vj   = bus.in_Vj;
   assign vk   = bus.in_Vk;
   assign imm  = bus.in_imm;
   assign pc   = bus.in_pc;
   assign lt_s = $signed(vj) < $signed(vk);
   assign lt_u = vj < vk;
   assign eq   = vj == vk;

   always_comb begin
      known        = 1'b1;
      res_data     = '0;
      res_target   = '0;
      res_isload   = 1'b0;
      res_br_valid = 1'b0;
      res_taken    = 1'b0;
      case (bus.in_op)
         OP_ADD:   res_data = vj + vk;
         OP_SUB:   res_data = vj - vk;
         OP_AND:   res_data = vj & vk;
         OP_OR:    res_data = vj | vk;
         OP_XOR:   res_data = vj ^ vk;
         OP_ADDI:  res_data = vj + imm;
         OP_ANDI:  res_data = vj & imm;
         OP_ORI:   res_data = vj | imm;
         OP_XORI:  res_data = vj ^ imm;
         OP_SLL:   res_data = vj << vk[SH_W-1:0];
         OP_SRL:   res_data = vj >> vk[SH_W-1:0];
         OP_SRA:   res_data = DATA_W'($signed(vj) >>> vk[SH_W-1:0]);
         OP_SLLI:  res_data = vj << imm[SH_W-1:0];
         OP_SRLI:  res_data = vj >> imm[SH_W-1:0];
         OP_SRAI:  res_data = DATA_W'($signed(vj) >>> imm[SH_W-1:0]);
         OP_SLT:   res_data = {{(DATA_W-1){1'b0}}, lt_s};
         OP_SLTU:  res_data = {{(DATA_W-1){1'b0}}, lt_u};
         OP_SLTI:  res_data = {{(DATA_W-1){1'b0}}, $signed(vj) < $signed(imm)};
         OP_SLTIU: res_data = {{(DATA_W-1){1'b0}}, vj < imm};
         OP_LUI:   res_data = imm;
         OP_AUIPC: res_data = pc + imm;
         OP_JAL, OP_JALR: begin
            res_data     = pc + DATA_W'(4);
            res_br_valid = 1'b1;
            res_taken    = 1'b1;
            res_target   = (bus.in_op == OP_JAL) ? pc + imm
                                                 : (vj + imm) & ~DATA_W'(1);
         end
         OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
            case (bus.in_op)
               OP_BEQ:  res_taken = eq;
               OP_BNE:  res_taken = !eq;
               OP_BLT:  res_taken = lt_s;
               OP_BGE:  res_taken = !lt_s;
               OP_BLTU: res_taken = lt_u;
               default: res_taken = !lt_u;
            endcase
            res_br_valid = 1'b1;
            res_target   = pc + imm;
            res_data     = {{(DATA_W-1){1'b0}}, res_taken};
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: begin
            res_data   = vj + imm;
            res_isload = 1'b1;
         end
         default: known = 1'b0;
      endcase
   end

   // NOP and unknown codes both fall into the default arm, so an empty slot never broadcasts.
   assign slot_valid = known && (bus.in_rob_tag != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q <= '0; data_q <= '0; target_q <= '0;
         isload_q <= 1'b0; br_valid_q <= 1'b0; taken_q <= 1'b0;
         issue_cnt_q <= '0; taken_cnt_q <= '0;
      end else if (bus.in_flush) begin
         tag_q <= '0; data_q <= '0; target_q <= '0;
         isload_q <= 1'b0; br_valid_q <= 1'b0; taken_q <= 1'b0;
      end else if (bus.ena) begin
         tag_q      <= slot_valid ? bus.in_rob_tag : '0;
         data_q     <= slot_valid ? res_data : '0;
         target_q   <= slot_valid ? res_target : '0;
         isload_q   <= slot_valid && res_isload;
         br_valid_q <= slot_valid && res_br_valid;
         taken_q    <= slot_valid && res_taken;
         if (slot_valid) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
         if (slot_valid && res_taken) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      end
   end

   assign bus.out_cdb_rob_tag = tag_q;
   assign bus.out_cdb_data    = data_q;
   assign bus.out_cdb_isload  = isload_q;
   assign bus.out_br_valid    = br_valid_q;
   assign bus.out_br_taken    = taken_q;
   assign bus.out_br_target   = target_q;
   assign bus.out_issue_cnt   = issue_cnt_q;
   assign bus.out_taken_cnt   = taken_cnt_q;
endmodule
